pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_perf_cnt.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// register-index width and the register-match helper.
package pipe_pkg;

    localparam int REG_W  = 5;
    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2,
        ST_ILLEGAL  = 2'd3
    } ctrl_state_e;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    function automatic logic reg_hit(input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs,
                                     input logic             use_rs);
        return use_rs && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running stall and flush event counters; both wrap at 2^32.
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall) stall_cnt <= stall_cnt + 32'd1;
            if (flush) flush_cnt <= flush_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM with timeout, branch flush and
// load-use bubble. Define PIPE_CTRL_PERF_EN to add stall/flush counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_hold,
    output logic [1:0]       ctrl_state,
    output logic             mem_timeout_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    localparam logic [WAIT_W:0] TIMEOUT = MEM_TIMEOUT[WAIT_W:0];

    ctrl_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_hit;
    logic              branch_pend;
    logic              mem_stall;
    logic              load_use;
    logic              branch_flush;

    assign wait_hit = ({1'b0, wait_cnt} + 1'b1) >= TIMEOUT;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (dmem_req && !dmem_ready) state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                if (dmem_ready)    state_d = ST_RUN;
                else if (wait_hit) state_d = ST_ERR;
            end
            ST_ERR:      state_d = ST_ERR;
            default:     state_d = ST_RUN;
        endcase
    end

    // Counter idles at zero outside MEM_WAIT, which clears it on entry.
    always_ff @(posedge clk) begin
        if (reset || state_q != ST_MEM_WAIT) wait_cnt <= '0;
        else if (wait_cnt != '1)             wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)                 mem_timeout_err <= 1'b0;
        else if (state_d == ST_ERR) mem_timeout_err <= 1'b1;
    end

    // EX is frozen while memory stalls, so a taken branch seen then is
    // remembered and flushed in the first unstalled cycle.
    always_ff @(posedge clk) begin
        if (reset)          branch_pend <= 1'b0;
        else if (mem_stall) branch_pend <= branch_pend | ex_branch_taken;
        else                branch_pend <= 1'b0;
    end

    assign mem_stall    = (state_q == ST_MEM_WAIT) ||
                          (state_q == ST_RUN && dmem_req && !dmem_ready);
    assign load_use     = ex_mem_read && (reg_hit(ex_rd, id_rs1, id_use_rs1) ||
                                          reg_hit(ex_rd, id_rs2, id_use_rs2));
    assign branch_flush = ex_branch_taken || branch_pend;

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_hold   = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (mem_stall || state_q == ST_ERR || state_q == ST_ILLEGAL) begin
            // The illegal encoding freezes for its single recovery cycle.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
        end else if (branch_flush) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign ctrl_state = state_q;

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_cnt u_perf (
        .clk       (clk),
        .reset     (reset),
        .stall     (!pc_write),
        .flush     (if_id_flush),
        .stall_cnt (perf_stall_cnt),
        .flush_cnt (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; outputs are checked on the falling
// edge as {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic       dmem_req, dmem_ready;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold;
    logic [1:0] ctrl_state;
    logic       mem_timeout_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
    logic [4:0] outs;

    int vec  = 0;
    int miss = 0;

    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold};

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .pipe_hold       (pipe_hold),
        .ctrl_state      (ctrl_state),
        .mem_timeout_err (mem_timeout_err)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0; ex_branch_taken = 0;
        dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        dmem_req = 1; ex_branch_taken = 1; ex_mem_read = 1;
        ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        tick(); tick();
        @(negedge clk);
        vec++;
        if (outs !== 5'b00000) begin miss++; $display("FAIL reset_outs: got %b want 00000", outs); end
        vec++;
        if (ctrl_state !== 2'd0 || mem_timeout_err !== 1'b0) begin
            miss++; $display("FAIL reset_state: got st=%0d err=%b want st=0 err=0", ctrl_state, mem_timeout_err);
        end
        tick();
        reset = 0; clr();
        @(negedge clk);
        vec++;
        if (outs !== 5'b11000) begin miss++; $display("FAIL normal_after_reset: got %b want 11000", outs); end
        tick();
    endtask

    task automatic test_load_use();
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        @(negedge clk);
        vec++;
        if (outs !== 5'b00010) begin miss++; $display("FAIL load_use_rs1: got %b want 00010", outs); end
        tick();
        clr();
        @(negedge clk);
        vec++;
        if (outs !== 5'b11000) begin miss++; $display("FAIL load_use_single: got %b want 11000", outs); end
        tick();
        ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1; id_rs1 = 3; id_use_rs1 = 1;
        @(negedge clk);
        vec++;
        if (outs !== 5'b00010) begin miss++; $display("FAIL load_use_rs2: got %b want 00010", outs); end
        tick();
        ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0; id_rs2 = 1; id_use_rs2 = 1;
        @(negedge clk);
        vec++;
        if (outs !== 5'b11000) begin miss++; $display("FAIL unused_src: got %b want 11000", outs); end
        tick();
        ex_mem_read = 0; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
        @(negedge clk);
        vec++;
        if (outs !== 5'b11000) begin miss++; $display("FAIL not_load: got %b want 11000", outs); end
        tick();
        clr();
    endtask

    task automatic test_x0();
        ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
        @(negedge clk);
        vec++;
        if (outs !== 5'b11000) begin miss++; $display("FAIL x0_exclusion: got %b want 11000", outs); end
        tick();
        clr();
    endtask

    task automatic test_branch();
        ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        @(negedge clk);
        vec++;
        if (outs !== 5'b11110) begin miss++; $display("FAIL branch_over_load_use: got %b want 11110", outs); end
        tick();
        clr();
        @(negedge clk);
        vec++;
        if (outs !== 5'b11000) begin miss++; $display("FAIL branch_single: got %b want 11000", outs); end
        tick();
        ex_branch_taken = 1; dmem_req = 1; dmem_ready = 1;
        @(negedge clk);
        vec++;
        if (outs !== 5'b11110 || ctrl_state !== 2'd0) begin
            miss++; $display("FAIL branch_ready_mem: got %b st=%0d want 11110 st=0", outs, ctrl_state);
        end
        tick();
        clr();
    endtask

    task automatic test_mem_wait();
        dmem_req = 1; dmem_ready = 0;
        @(negedge clk);
        vec++;
        if (outs !== 5'b00001 || ctrl_state !== 2'd0) begin
            miss++; $display("FAIL mem_wait_c1: got %b st=%0d want 00001 st=0", outs, ctrl_state);
        end
        tick();
        ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vec++;
            if (outs !== 5'b00001 || ctrl_state !== 2'd1) begin
                miss++; $display("FAIL mem_wait_hold%0d: got %b st=%0d want 00001 st=1", i, outs, ctrl_state);
            end
            tick();
        end
        dmem_ready = 1;
        @(negedge clk);
        vec++;
        if (outs !== 5'b00001 || ctrl_state !== 2'd1) begin
            miss++; $display("FAIL mem_wait_ready: got %b st=%0d want 00001 st=1", outs, ctrl_state);
        end
        tick();
        clr();
        @(negedge clk);
        vec++;
        if (outs !== 5'b11110 || ctrl_state !== 2'd0) begin
            miss++; $display("FAIL held_branch_flush: got %b st=%0d want 11110 st=0", outs, ctrl_state);
        end
        tick();
        @(negedge clk);
        vec++;
        if (outs !== 5'b11000) begin miss++; $display("FAIL held_branch_single: got %b want 11000", outs); end
        tick();
    endtask

    task automatic test_timeout();
        dmem_req = 1; dmem_ready = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++;
            if (ctrl_state !== 2'd1 || mem_timeout_err !== 1'b0) begin
                miss++; $display("FAIL timeout_wait%0d: got st=%0d err=%b want st=1 err=0", i, ctrl_state, mem_timeout_err);
            end
            tick();
        end
        @(negedge clk);
        vec++;
        if (ctrl_state !== 2'd2 || mem_timeout_err !== 1'b1 || outs !== 5'b00001) begin
            miss++; $display("FAIL timeout_err: got st=%0d err=%b outs=%b want st=2 err=1 outs=00001", ctrl_state, mem_timeout_err, outs);
        end
        tick();
        dmem_req = 0; dmem_ready = 1; ex_branch_taken = 1;
        tick();
        @(negedge clk);
        vec++;
        if (ctrl_state !== 2'd2 || mem_timeout_err !== 1'b1 || outs !== 5'b00001) begin
            miss++; $display("FAIL err_sticky: got st=%0d err=%b outs=%b want st=2 err=1 outs=00001", ctrl_state, mem_timeout_err, outs);
        end
        tick();
        reset = 1;
        @(negedge clk);
        vec++;
        if (outs !== 5'b00000) begin miss++; $display("FAIL reset_in_err: got %b want 00000", outs); end
        tick();
        reset = 0; clr();
        @(negedge clk);
        vec++;
        if (ctrl_state !== 2'd0 || mem_timeout_err !== 1'b0 || outs !== 5'b11000) begin
            miss++; $display("FAIL err_cleared: got st=%0d err=%b outs=%b want st=0 err=0 outs=11000", ctrl_state, mem_timeout_err, outs);
        end
        tick();
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        reset = 1; clr();
        tick();
        reset = 0;
        tick();
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        tick();
        clr();
        tick();
        ex_mem_read = 1; ex_rd = 6; id_rs2 = 6; id_use_rs2 = 1;
        tick();
        clr();
        ex_branch_taken = 1;
        tick();
        clr();
        @(negedge clk);
        vec++;
        if (perf_stall_cnt !== 32'd2 || perf_flush_cnt !== 32'd1) begin
            miss++; $display("FAIL perf_counts: got stall=%0d flush=%0d want stall=2 flush=1", perf_stall_cnt, perf_flush_cnt);
        end
        tick();
    endtask
`endif

    initial begin
        reset = 1;
        clr();
        test_reset();
        test_load_use();
        test_x0();
        test_branch();
        test_mem_wait();
        test_timeout();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
